// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Two-player arcade control mapper. Merges PS/2 key latches with two
//   joypads, applies optional 90-degree rotation, shapes coin requests into
//   fixed-length pulses and, when INPUT_AUTOFIRE_EN is defined, gates masked
//   fire buttons with a free-running autofire phase.
//   Optional build macro: INPUT_AUTOFIRE_EN (undefined: af_mask is ignored,
//   no autofire counter exists, fire buttons pass straight through).
//   Start buttons from either pad drive start1/start2. Pad 0's coin button
//   requests coin1 and pad 1's coin button requests coin2.

module arcade_input_mapper #(
  parameter int BUTTONS    = 1,        // fire buttons per player, 1..4
  parameter int COIN_PULSE = 1200000,  // coin high time in clk_sys cycles, >= 2
  parameter int AF_HALF    = 300000    // autofire half-period in clk_sys cycles, >= 1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        ps2_key,        // {toggle, pressed, extended, code}
  input  logic [15:0]        joystick_0,
  input  logic [15:0]        joystick_1,
  input  logic               merge_joy,
  input  logic               rotate,
  input  logic               rotate_ccw,
  input  logic               coin_on_start,
  input  logic [BUTTONS-1:0] af_mask,
  output logic [3:0]         p1_dir,         // {up, down, left, right}
  output logic [3:0]         p2_dir,
  output logic [BUTTONS-1:0] p1_fire,
  output logic [BUTTONS-1:0] p2_fire,
  output logic               start1,
  output logic               start2,
  output logic               coin1,
  output logic               coin2
);

  // Key latch vector layout. Direction groups are {up, down, left, right}.
  localparam int K_P1_DIR  = 0;
  localparam int K_P1_FIRE = 4;
  localparam int K_P2_DIR  = 8;
  localparam int K_P2_FIRE = 12;
  localparam int K_START1  = 16;
  localparam int K_START2  = 17;
  localparam int K_COIN1   = 18;
  localparam int K_COIN2   = 19;
  localparam int NKEYS     = 20;

  // Fire latches above BUTTONS-1 can never be written.
  localparam logic [3:0]       FIRE_OK = 4'((1 << BUTTONS) - 1);
  localparam logic [NKEYS-1:0] KEY_OK  = {4'hF, FIRE_OK, 4'hF, FIRE_OK, 4'hF};

  // Pad bit positions that depend on the number of fire buttons.
  localparam int J_START1 = 4 + BUTTONS;
  localparam int J_START2 = 5 + BUTTONS;
  localparam int J_COIN   = 6 + BUTTONS;

  localparam int CW = $clog2(COIN_PULSE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_HOLD
  } coin_state_t;

  // ---------------------------------------------------------------------------
  // PS/2 event detection and key latches
  // ---------------------------------------------------------------------------
  logic             r_primed;
  logic             r_old_toggle;
  logic [NKEYS-1:0] r_keys;
  logic [NKEYS-1:0] w_key_hit;
  logic [NKEYS-1:0] w_key_sel;
  logic             w_key_event;

  assign w_key_event = r_primed & (ps2_key[10] ^ r_old_toggle);
  assign w_key_sel   = w_key_hit & KEY_OK;

  // Decode the scan code into the one latch it controls; the extended bit
  // never participates, so both left Ctrl (14) and right Ctrl (E014) fire.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_key_hit unassigned,
    // which would otherwise infer a latch.
    w_key_hit = '0;
    case (ps2_key[7:0])
      8'h75:        w_key_hit[K_P1_DIR + 3]  = 1'b1;
      8'h72:        w_key_hit[K_P1_DIR + 2]  = 1'b1;
      8'h6B:        w_key_hit[K_P1_DIR + 1]  = 1'b1;
      8'h74:        w_key_hit[K_P1_DIR + 0]  = 1'b1;
      8'h14, 8'h29: w_key_hit[K_P1_FIRE + 0] = 1'b1;
      8'h11:        w_key_hit[K_P1_FIRE + 1] = 1'b1;
      8'h12:        w_key_hit[K_P1_FIRE + 2] = 1'b1;
      8'h1A:        w_key_hit[K_P1_FIRE + 3] = 1'b1;
      8'h2D:        w_key_hit[K_P2_DIR + 3]  = 1'b1;
      8'h2B:        w_key_hit[K_P2_DIR + 2]  = 1'b1;
      8'h23:        w_key_hit[K_P2_DIR + 1]  = 1'b1;
      8'h34:        w_key_hit[K_P2_DIR + 0]  = 1'b1;
      8'h1C:        w_key_hit[K_P2_FIRE + 0] = 1'b1;
      8'h1B:        w_key_hit[K_P2_FIRE + 1] = 1'b1;
      8'h15:        w_key_hit[K_P2_FIRE + 2] = 1'b1;
      8'h1D:        w_key_hit[K_P2_FIRE + 3] = 1'b1;
      8'h05, 8'h16: w_key_hit[K_START1]      = 1'b1;
      8'h06, 8'h1E: w_key_hit[K_START2]      = 1'b1;
      8'h2E:        w_key_hit[K_COIN1]       = 1'b1;
      8'h36:        w_key_hit[K_COIN2]       = 1'b1;
      default:      w_key_hit = '0;
    endcase
  end

  // Track the toggle bit; the first cycle after reset only primes it so a
  // toggle level left over from before reset is not taken as a key event.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others, exactly as the hardware does.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_primed     <= 1'b0;
      r_old_toggle <= 1'b0;
      r_keys       <= '0;
    end else begin
      r_old_toggle <= ps2_key[10];
      r_primed     <= 1'b1;
      if (w_key_event) begin
        r_keys <= (r_keys & ~w_key_sel) | (w_key_sel & {NKEYS{ps2_key[9]}});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Player sources
  // ---------------------------------------------------------------------------
  logic [3:0]         w_p1_dir_raw;
  logic [3:0]         w_p2_dir_raw;
  logic [BUTTONS-1:0] w_p1_fire_raw;
  logic [BUTTONS-1:0] w_p2_fire_raw;
  logic               w_start1;
  logic               w_start2;
  logic [1:0]         w_coin_req;
  logic [BUTTONS-1:0] w_af_gate;
  logic               w_unused;

  assign w_p1_dir_raw  = r_keys[K_P1_DIR +: 4] | joystick_0[3:0]
                       | ({4{merge_joy}} & joystick_1[3:0]);
  assign w_p2_dir_raw  = r_keys[K_P2_DIR +: 4] | joystick_1[3:0]
                       | ({4{merge_joy}} & joystick_0[3:0]);
  assign w_p1_fire_raw = r_keys[K_P1_FIRE +: BUTTONS] | joystick_0[4 +: BUTTONS]
                       | ({BUTTONS{merge_joy}} & joystick_1[4 +: BUTTONS]);
  assign w_p2_fire_raw = r_keys[K_P2_FIRE +: BUTTONS] | joystick_1[4 +: BUTTONS]
                       | ({BUTTONS{merge_joy}} & joystick_0[4 +: BUTTONS]);

  assign w_start1 = r_keys[K_START1] | joystick_0[J_START1] | joystick_1[J_START1];
  assign w_start2 = r_keys[K_START2] | joystick_0[J_START2] | joystick_1[J_START2];

  assign w_coin_req[0] = r_keys[K_COIN1] | joystick_0[J_COIN]
                       | (coin_on_start & (w_start1 | w_start2));
  assign w_coin_req[1] = r_keys[K_COIN2] | joystick_1[J_COIN];

  // Bits with no function here (upper pad bits, the extended flag, and
  // af_mask in the non-autofire build) are gathered so they read as consumed.
  assign w_unused = ^{ps2_key[8], joystick_0, joystick_1, af_mask};

  // Rotate a {up, down, left, right} group by 90 degrees.
  function automatic logic [3:0] rotate_dir(input logic [3:0] d,
                                            input logic       en,
                                            input logic       ccw);
    if (!en)       return d;
    else if (!ccw) return {d[1], d[0], d[2], d[3]};  // up<-left, down<-right, left<-down, right<-up
    else           return {d[0], d[1], d[3], d[2]};  // up<-right, down<-left, left<-up, right<-down
  endfunction

  // ---------------------------------------------------------------------------
  // Autofire
  // ---------------------------------------------------------------------------
`ifdef INPUT_AUTOFIRE_EN
  localparam int AFW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;

  // Free-running divider: flip the phase once every AF_HALF cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AFW'(AF_HALF - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + 1'b1;
    end
  end

  assign w_af_gate = ~af_mask | {BUTTONS{r_af_phase}};
`else
  assign w_af_gate = '1;
`endif

  // ---------------------------------------------------------------------------
  // Registered player outputs
  // ---------------------------------------------------------------------------
  // One register stage from the merged sources to every player output.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_dir  <= '0;
      p2_dir  <= '0;
      p1_fire <= '0;
      p2_fire <= '0;
      start1  <= 1'b0;
      start2  <= 1'b0;
    end else begin
      p1_dir  <= rotate_dir(w_p1_dir_raw, rotate, rotate_ccw);
      p2_dir  <= rotate_dir(w_p2_dir_raw, rotate, rotate_ccw);
      p1_fire <= w_p1_fire_raw & w_af_gate;
      p2_fire <= w_p2_fire_raw & w_af_gate;
      start1  <= w_start1;
      start2  <= w_start2;
    end
  end

  // ---------------------------------------------------------------------------
  // Coin pulse shaping
  // ---------------------------------------------------------------------------
  coin_state_t r_coin_st  [2];
  logic [CW-1:0] r_coin_cnt [2];
  logic [1:0]  r_coin_req_d;
  logic [1:0]  r_coin_out;

  // Per coin: a request rising edge starts one COIN_PULSE-long pulse; a
  // request still held when it ends parks in HOLD until released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_coin_st[i]  <= S_IDLE;
        r_coin_cnt[i] <= '0;
      end
      r_coin_req_d <= '0;
      r_coin_out   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_coin_req_d[i] <= w_coin_req[i];
        case (r_coin_st[i])
          S_IDLE: begin
            if (w_coin_req[i] && !r_coin_req_d[i]) begin
              r_coin_st[i]  <= S_PULSE;
              r_coin_out[i] <= 1'b1;
              r_coin_cnt[i] <= CW'(COIN_PULSE - 1);
            end
          end
          S_PULSE: begin
            if (r_coin_cnt[i] == '0) begin
              r_coin_out[i] <= 1'b0;
              r_coin_st[i]  <= w_coin_req[i] ? S_HOLD : S_IDLE;
            end else begin
              r_coin_cnt[i] <= r_coin_cnt[i] - 1'b1;
            end
          end
          S_HOLD: begin
            if (!w_coin_req[i]) r_coin_st[i] <= S_IDLE;
          end
          default: begin
            r_coin_st[i]  <= S_IDLE;
            r_coin_out[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign coin1 = r_coin_out[0];
  assign coin2 = r_coin_out[1];

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper
//   Self-checking bench for arcade_input_mapper with BUTTONS=2, COIN_PULSE=4,
//   AF_HALF=3. Directed scenarios plus a randomized run against a
//   name-level reference model of the key latches, pad merge and rotation.

module tb_arcade_input_mapper;

  localparam int B   = 2;
  localparam int CP  = 4;
  localparam int AFH = 3;

  // Direction names used by the model.
  localparam int UP = 0, DN = 1, LT = 2, RT = 3;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic [10:0]  ps2_key;
  logic [15:0]  joystick_0;
  logic [15:0]  joystick_1;
  logic         merge_joy;
  logic         rotate;
  logic         rotate_ccw;
  logic         coin_on_start;
  logic [B-1:0] af_mask;
  logic [3:0]   p1_dir;
  logic [3:0]   p2_dir;
  logic [B-1:0] p1_fire;
  logic [B-1:0] p2_fire;
  logic         start1;
  logic         start2;
  logic         coin1;
  logic         coin2;

  int checks   = 0;
  int failures = 0;

  arcade_input_mapper #(
    .BUTTONS    (B),
    .COIN_PULSE (CP),
    .AF_HALF    (AFH)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joystick_0    (joystick_0),
    .joystick_1    (joystick_1),
    .merge_joy     (merge_joy),
    .rotate        (rotate),
    .rotate_ccw    (rotate_ccw),
    .coin_on_start (coin_on_start),
    .af_mask       (af_mask),
    .p1_dir        (p1_dir),
    .p2_dir        (p2_dir),
    .p1_fire       (p1_fire),
    .p2_fire       (p2_fire),
    .start1        (start1),
    .start2        (start2),
    .coin1         (coin1),
    .coin2         (coin2)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_inputs();
    ps2_key       = '0;
    joystick_0    = '0;
    joystick_1    = '0;
    merge_joy     = 1'b0;
    rotate        = 1'b0;
    rotate_ccw    = 1'b0;
    coin_on_start = 1'b0;
    af_mask       = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
  endtask

  task automatic send_key(input logic [7:0] code, input logic pressed, input logic ext);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  // Coin observation counters, updated once per sampled cycle.
  int   c1_high, c1_rise, c2_high, c2_rise;
  logic c1_prev, c2_prev;

  task automatic coin_clear();
    c1_high = 0; c1_rise = 0; c2_high = 0; c2_rise = 0;
    c1_prev = coin1; c2_prev = coin2;
  endtask

  task automatic coin_ticks(input int n);
    repeat (n) begin
      tick();
      if (coin1) c1_high++;
      if (coin2) c2_high++;
      if (coin1 && !c1_prev) c1_rise++;
      if (coin2 && !c2_prev) c2_rise++;
      c1_prev = coin1;
      c2_prev = coin2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: key state by player and name, pads, mode bits.
  // ---------------------------------------------------------------------------
  bit          m_dir   [2][4];
  bit          m_fire  [2][4];
  bit          m_start [2];
  logic [15:0] m_pad   [2];

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        m_dir[p][k]  = 1'b0;
        m_fire[p][k] = 1'b0;
      end
      m_start[p] = 1'b0;
    end
  endtask

  task automatic model_key(input logic [7:0] code, input bit pressed);
    case (code)
      8'h75: m_dir[0][UP] = pressed;
      8'h72: m_dir[0][DN] = pressed;
      8'h6B: m_dir[0][LT] = pressed;
      8'h74: m_dir[0][RT] = pressed;
      8'h14, 8'h29: m_fire[0][0] = pressed;
      8'h11: m_fire[0][1] = pressed;
      8'h12: m_fire[0][2] = pressed;
      8'h1A: m_fire[0][3] = pressed;
      8'h2D: m_dir[1][UP] = pressed;
      8'h2B: m_dir[1][DN] = pressed;
      8'h23: m_dir[1][LT] = pressed;
      8'h34: m_dir[1][RT] = pressed;
      8'h1C: m_fire[1][0] = pressed;
      8'h1B: m_fire[1][1] = pressed;
      8'h15: m_fire[1][2] = pressed;
      8'h1D: m_fire[1][3] = pressed;
      8'h05, 8'h16: m_start[0] = pressed;
      8'h06, 8'h1E: m_start[1] = pressed;
      default: ;
    endcase
  endtask

  // Pad direction bit for a named direction: R=0, L=1, D=2, U=3.
  function automatic bit pad_dir(input logic [15:0] pad, input int d);
    case (d)
      UP:      return pad[3];
      DN:      return pad[2];
      LT:      return pad[1];
      default: return pad[0];
    endcase
  endfunction

  function automatic logic [3:0] model_dir(input int p, input bit mrg, input bit rot, input bit ccw);
    bit v [4];
    bit o [4];
    for (int d = 0; d < 4; d++)
      v[d] = m_dir[p][d] | pad_dir(m_pad[p], d) | (mrg & pad_dir(m_pad[1-p], d));
    if (!rot) begin
      o = v;
    end else if (!ccw) begin
      o[UP] = v[LT]; o[DN] = v[RT]; o[LT] = v[DN]; o[RT] = v[UP];
    end else begin
      o[UP] = v[RT]; o[DN] = v[LT]; o[LT] = v[UP]; o[RT] = v[DN];
    end
    return {o[UP], o[DN], o[LT], o[RT]};
  endfunction

  function automatic logic [B-1:0] model_fire(input int p, input bit mrg);
    logic [B-1:0] r;
    for (int i = 0; i < B; i++)
      r[i] = m_fire[p][i] | m_pad[p][4+i] | (mrg & m_pad[1-p][4+i]);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] outs;
    reset_n    = 1'b0;
    clear_inputs();
    joystick_0 = 16'hFFFF;
    joystick_1 = 16'hFFFF;
    ticks(3);
    outs = {p1_dir, p2_dir, p1_fire, p2_fire, start1, start2, coin1, coin2};
    if (outs !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0000", outs);
    end
    checks++;
    do_reset();
    outs = {p1_dir, p2_dir, p1_fire, p2_fire, start1, start2, coin1, coin2};
    if (outs !== 16'h0) begin
      failures++;
      $display("FAIL reset_release_outputs: got %h expected 0000", outs);
    end
    checks++;
  endtask

  task automatic test_key_latency();
    do_reset();
    send_key(8'h75, 1'b1, 1'b1);
    tick();
    if (p1_dir !== 4'b0000) begin
      failures++;
      $display("FAIL key_edge_n: p1_dir got %b expected 0000", p1_dir);
    end
    checks++;
    tick();
    if (p1_dir !== 4'b1000) begin
      failures++;
      $display("FAIL key_edge_n1: p1_dir got %b expected 1000", p1_dir);
    end
    checks++;
    send_key(8'h75, 1'b0, 1'b1);
    ticks(2);
    if (p1_dir !== 4'b0000) begin
      failures++;
      $display("FAIL key_release: p1_dir got %b expected 0000", p1_dir);
    end
    checks++;
  endtask

  task automatic test_priming();
    reset_n = 1'b0;
    clear_inputs();
    ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
    ticks(2);
    reset_n = 1'b1;
    ticks(4);
    if (p1_dir !== 4'b0000) begin
      failures++;
      $display("FAIL priming: p1_dir got %b expected 0000", p1_dir);
    end
    checks++;
    send_key(8'h75, 1'b1, 1'b1);
    ticks(2);
    if (p1_dir !== 4'b1000) begin
      failures++;
      $display("FAIL after_priming: p1_dir got %b expected 1000", p1_dir);
    end
    checks++;
  endtask

  task automatic test_pad_and_unlisted();
    do_reset();
    joystick_0 = 16'h0008;
    tick();
    if (p1_dir !== 4'b1000) begin
      failures++;
      $display("FAIL pad_latency: p1_dir got %b expected 1000", p1_dir);
    end
    checks++;
    joystick_0 = 16'h0000;
    send_key(8'h77, 1'b1, 1'b0);
    tick();
    send_key(8'h5A, 1'b1, 1'b1);
    ticks(3);
    if ({p1_dir, p2_dir, p1_fire, p2_fire, start1, start2} !== 14'h0) begin
      failures++;
      $display("FAIL unlisted_codes: got %b %b %b %b %b %b expected all zero",
               p1_dir, p2_dir, p1_fire, p2_fire, start1, start2);
    end
    checks++;
  endtask

  task automatic test_rotate();
    do_reset();
    rotate     = 1'b1;
    joystick_0 = 16'h0002;   // P1 left
    joystick_1 = 16'h0008;   // P2 up
    tick();
    if (p1_dir !== 4'b1000 || p2_dir !== 4'b0001) begin
      failures++;
      $display("FAIL rotate_cw: p1 %b p2 %b expected 1000 0001", p1_dir, p2_dir);
    end
    checks++;
    rotate_ccw = 1'b1;
    tick();
    if (p1_dir !== 4'b0100 || p2_dir !== 4'b0010) begin
      failures++;
      $display("FAIL rotate_ccw: p1 %b p2 %b expected 0100 0010", p1_dir, p2_dir);
    end
    checks++;
    rotate = 1'b0;
    tick();
    if (p1_dir !== 4'b0010 || p2_dir !== 4'b1000) begin
      failures++;
      $display("FAIL rotate_off: p1 %b p2 %b expected 0010 1000", p1_dir, p2_dir);
    end
    checks++;
  endtask

  task automatic test_merge();
    do_reset();
    merge_joy  = 1'b1;
    joystick_1 = 16'h0020;   // P2 fire1
    tick();
    if (p1_fire !== 2'b10 || p2_fire !== 2'b10) begin
      failures++;
      $display("FAIL merge_on: p1_fire %b p2_fire %b expected 10 10", p1_fire, p2_fire);
    end
    checks++;
    merge_joy = 1'b0;
    tick();
    if (p1_fire !== 2'b00 || p2_fire !== 2'b10) begin
      failures++;
      $display("FAIL merge_off: p1_fire %b p2_fire %b expected 00 10", p1_fire, p2_fire);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_key(8'h74, 1'b1, 1'b1);   // key right
    joystick_0 = 16'h0002;          // pad left, same cycle
    tick();
    if (p1_dir !== 4'b0010) begin
      failures++;
      $display("FAIL same_cycle_edge_n: p1_dir got %b expected 0010", p1_dir);
    end
    checks++;
    tick();
    if (p1_dir !== 4'b0011) begin
      failures++;
      $display("FAIL same_cycle_edge_n1: p1_dir got %b expected 0011", p1_dir);
    end
    checks++;
  endtask

  task automatic test_coin();
    // Held 20 cycles: exactly one pulse of CP cycles; release and re-press: another.
    do_reset();
    coin_clear();
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(20);
    if (c1_high != CP || c1_rise != 1) begin
      failures++;
      $display("FAIL coin_held: high=%0d pulses=%0d expected %0d 1", c1_high, c1_rise, CP);
    end
    checks++;
    send_key(8'h2E, 1'b0, 1'b0);
    coin_ticks(3);
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(20);
    if (c1_high != 2*CP || c1_rise != 2) begin
      failures++;
      $display("FAIL coin_repress: high=%0d pulses=%0d expected %0d 2", c1_high, c1_rise, 2*CP);
    end
    checks++;

    // Re-press during the pulse is ignored.
    do_reset();
    coin_clear();
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(1);
    send_key(8'h2E, 1'b0, 1'b0);
    coin_ticks(1);
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(20);
    if (c1_high != CP || c1_rise != 1) begin
      failures++;
      $display("FAIL coin_ignore_repress: high=%0d pulses=%0d expected %0d 1", c1_high, c1_rise, CP);
    end
    checks++;

    // Short press: pulse still full length, then a later press pulses again.
    do_reset();
    coin_clear();
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(1);
    send_key(8'h2E, 1'b0, 1'b0);
    coin_ticks(9);
    send_key(8'h2E, 1'b1, 1'b0);
    coin_ticks(20);
    if (c1_high != 2*CP || c1_rise != 2 || c2_high != 0) begin
      failures++;
      $display("FAIL coin_short_press: high=%0d pulses=%0d coin2=%0d expected %0d 2 0",
               c1_high, c1_rise, c2_high, 2*CP);
    end
    checks++;
  endtask

  task automatic test_coin_sources();
    do_reset();
    coin_on_start = 1'b1;
    coin_clear();
    send_key(8'h16, 1'b1, 1'b0);
    coin_ticks(15);
    if (c1_high != CP || c1_rise != 1 || c2_high != 0) begin
      failures++;
      $display("FAIL coin_on_start: coin1 high=%0d pulses=%0d coin2 high=%0d expected %0d 1 0",
               c1_high, c1_rise, c2_high, CP);
    end
    checks++;
    send_key(8'h16, 1'b0, 1'b0);
    coin_on_start = 1'b0;
    coin_ticks(3);
    coin_clear();
    send_key(8'h05, 1'b1, 1'b0);
    coin_ticks(15);
    if (c1_high != 0 || start1 !== 1'b1) begin
      failures++;
      $display("FAIL start_no_coin: coin1 high=%0d start1=%b expected 0 1", c1_high, start1);
    end
    checks++;
    coin_clear();
    joystick_1[6+B] = 1'b1;
    coin_ticks(15);
    if (c2_high != CP || c2_rise != 1 || c1_high != 0) begin
      failures++;
      $display("FAIL coin2_pad: coin2 high=%0d pulses=%0d coin1 high=%0d expected %0d 1 0",
               c2_high, c2_rise, c1_high, CP);
    end
    checks++;
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    send_key(8'h2E, 1'b1, 1'b0);
    ticks(3);
    if (coin1 !== 1'b1) begin
      failures++;
      $display("FAIL mid_pulse_setup: coin1 got %b expected 1", coin1);
    end
    checks++;
    #2;
    reset_n = 1'b0;
    #1;
    if (coin1 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_coin: coin1 got %b expected 0", coin1);
    end
    checks++;
    ticks(2);
    reset_n = 1'b1;
    coin_clear();
    coin_ticks(10);
    if (c1_high != 0) begin
      failures++;
      $display("FAIL after_reset_no_pulse: coin1 high=%0d expected 0", c1_high);
    end
    checks++;
  endtask

  task automatic test_autofire();
    logic s0 [40];
    int   ones1;
    do_reset();
    af_mask    = 2'b01;
    joystick_0 = 16'h0030;   // fire0 and fire1 held
    ones1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      s0[i] = p1_fire[0];
      if (p1_fire[1]) ones1++;
    end
    if (ones1 != 40) begin
      failures++;
      $display("FAIL af_unmasked: fire1 high %0d of 40 expected 40", ones1);
    end
    checks++;
`ifdef INPUT_AUTOFIRE_EN
    begin
      int last_edge;
      int runs;
      last_edge = -1;
      runs = 0;
      for (int i = 1; i < 40; i++) begin
        if (s0[i] !== s0[i-1]) begin
          if (last_edge >= 0) begin
            if (i - last_edge != AFH) begin
              failures++;
              $display("FAIL af_run_len: run ending at %0d length %0d expected %0d",
                       i, i - last_edge, AFH);
            end
            checks++;
            runs++;
          end
          last_edge = i;
        end
      end
      if (runs < 10) begin
        failures++;
        $display("FAIL af_toggling: full runs %0d expected at least 10", runs);
      end
      checks++;
    end
`else
    begin
      int ones0;
      ones0 = 0;
      for (int i = 0; i < 40; i++) if (s0[i] === 1'b1) ones0++;
      if (ones0 != 40) begin
        failures++;
        $display("FAIL af_disabled_steady: fire0 high %0d of 40 expected 40", ones0);
      end
      checks++;
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] codes [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h12,
                               8'h1A, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15,
                               8'h1D, 8'h05, 8'h16, 8'h06, 8'h1E, 8'h77, 8'h3C, 8'h4A};
    logic [3:0]   e1d, e2d;
    logic [B-1:0] e1f, e2f;
    bit           e_s1, e_s2;
    do_reset();
    model_clear();
    for (int it = 0; it < 300; it++) begin
      m_pad[0]   = 16'($urandom);
      m_pad[1]   = 16'($urandom);
      joystick_0 = m_pad[0];
      joystick_1 = m_pad[1];
      merge_joy  = 1'($urandom);
      rotate     = 1'($urandom);
      rotate_ccw = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        logic [7:0] c;
        bit         pr;
        c  = codes[$urandom_range(0, 23)];
        pr = 1'($urandom);
        send_key(c, pr, 1'($urandom));
        model_key(c, pr);
      end
      ticks(2);
      e1d  = model_dir(0, merge_joy, rotate, rotate_ccw);
      e2d  = model_dir(1, merge_joy, rotate, rotate_ccw);
      e1f  = model_fire(0, merge_joy);
      e2f  = model_fire(1, merge_joy);
      e_s1 = m_start[0] | m_pad[0][4+B] | m_pad[1][4+B];
      e_s2 = m_start[1] | m_pad[0][5+B] | m_pad[1][5+B];
      if (p1_dir !== e1d || p2_dir !== e2d) begin
        failures++;
        $display("FAIL rand_dir it=%0d: p1 %b p2 %b expected %b %b", it, p1_dir, p2_dir, e1d, e2d);
      end
      checks++;
      if (p1_fire !== e1f || p2_fire !== e2f) begin
        failures++;
        $display("FAIL rand_fire it=%0d: p1 %b p2 %b expected %b %b", it, p1_fire, p2_fire, e1f, e2f);
      end
      checks++;
      if (start1 !== e_s1 || start2 !== e_s2) begin
        failures++;
        $display("FAIL rand_start it=%0d: s1 %b s2 %b expected %b %b", it, start1, start2, e_s1, e_s2);
      end
      checks++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_key_latency();
    test_priming();
    test_pad_and_unlisted();
    test_rotate();
    test_merge();
    test_back_to_back();
    test_coin();
    test_coin_sources();
    test_reset_mid_pulse();
    test_autofire();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
